// File: rtl/hex_entry.sv
// hex_entry: debounced push/back/clear buttons assemble up to 32 hex nibbles from slide switches.
module hex_entry #(
    parameter int DB_BITS = 20
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [3:0]   sw,
    input  logic         btn_push,
    input  logic         btn_back,
    input  logic         btn_clear,
    output logic [0:127] o_x,
    output logic [5:0]   o_count,
    output logic         o_valid,
    output logic         o_done
);
    typedef enum logic [1:0] {EMPTY, ENTRY, FULL} state_t;
    state_t st;
    logic [3:0] sw_s1, sw_s2;
    logic [2:0] b_s1, b_s2, stable, stable_d, press;
    logic [DB_BITS-1:0] cnt [3];
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sw_s1    <= '0;
            sw_s2    <= '0;
            b_s1     <= '0;
            b_s2     <= '0;
            stable   <= '0;
            stable_d <= '0;
            press    <= '0;
            for (int k = 0; k < 3; k++) cnt[k] <= '0;
        end else begin
            sw_s1    <= sw;
            sw_s2    <= sw_s1;
            b_s1     <= {btn_clear, btn_back, btn_push};
            b_s2     <= b_s1;
            stable_d <= stable;
            press    <= stable & ~stable_d;
            // a level is accepted only after 2^DB_BITS consecutive disagreeing samples
            for (int k = 0; k < 3; k++) begin
                if (b_s2[k] == stable[k]) cnt[k] <= '0;
                else if (cnt[k] == '1) begin
                    cnt[k]    <= '0;
                    stable[k] <= ~stable[k];
                end else cnt[k] <= cnt[k] + 1'b1;
            end
        end
    end
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            st      <= EMPTY;
            o_x     <= '0;
            o_count <= '0;
            o_valid <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (press[2]) begin
                st      <= EMPTY;
                o_x     <= '0;
                o_count <= '0;
                o_valid <= 1'b0;
            end else if (press[1] && st != EMPTY) begin
                st      <= (o_count == 6'd1) ? EMPTY : ENTRY;
                o_x     <= {4'h0, o_x[0:123]};
                o_count <= o_count - 6'd1;
                o_valid <= 1'b0;
            end else if (press[0] && st != FULL) begin
                st      <= (o_count == 6'd31) ? FULL : ENTRY;
                o_x     <= {o_x[4:127], sw_s2};
                o_count <= o_count + 6'd1;
                o_valid <= o_count == 6'd31;
                o_done  <= o_count == 6'd31;
            end
        end
    end
endmodule
